// File: rtl/uni_arb2_if.sv
// uni_arb2_if: unified memory request interface, one requester to one responder.
interface uni_arb2_if #(
   parameter int UNI_ADDR_WIDTH = 32,
   parameter int UNI_DATA_WIDTH = 128
);
   logic                      valid;
   logic                      ready;
   logic                      reqtyp;
   logic [UNI_ADDR_WIDTH-1:0] addr;
   logic [1:0]                size;
   logic                      cachable;
   logic [UNI_DATA_WIDTH-1:0] wdata;
   logic [UNI_DATA_WIDTH-1:0] rdata;
   modport master (output valid, reqtyp, addr, size, cachable, wdata, input ready, rdata);
   modport slave  (input valid, reqtyp, addr, size, cachable, wdata, output ready, rdata);
endinterface

// File: rtl/uni_arb2.sv
// uni_arb2: round-robin arbiter, two uni_if masters onto one downstream slave.
// Grant is registered and held until the downstream ready pulse; one bubble follows.
module uni_arb2 #(
   parameter int UNI_ADDR_WIDTH = 32,
   parameter int UNI_DATA_WIDTH = 128
) (
   input  logic       i_clk,
   input  logic       i_rst,
   uni_arb2_if.slave  s0,
   uni_arb2_if.slave  s1,
   uni_arb2_if.master m,
   output logic       o_proto_err
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t r_state;
   logic   r_gnt;
   logic   r_last;
   logic                      w_busy;
   logic                      w_valid;
   logic [UNI_ADDR_WIDTH-1:0] w_addr;
   logic [UNI_DATA_WIDTH-1:0] w_wdata;
   logic [UNI_DATA_WIDTH-1:0] w_rdata;
   always_comb begin
      w_busy  = r_state == BUSY;
      w_valid = r_gnt ? s1.valid : s0.valid;
      w_addr  = r_gnt ? s1.addr : s0.addr;
      w_wdata = r_gnt ? s1.wdata : s0.wdata;
      w_rdata = w_busy ? m.rdata : '0;
   end
   assign m.valid    = w_busy & w_valid;
   assign m.reqtyp   = r_gnt ? s1.reqtyp : s0.reqtyp;
   assign m.addr     = w_addr;
   assign m.size     = r_gnt ? s1.size : s0.size;
   assign m.cachable = r_gnt ? s1.cachable : s0.cachable;
   assign m.wdata    = w_wdata;
   assign s0.ready   = w_busy & m.ready & ~r_gnt;
   assign s1.ready   = w_busy & m.ready & r_gnt;
   assign s0.rdata   = r_gnt ? '0 : w_rdata;
   assign s1.rdata   = r_gnt ? w_rdata : '0;
   // Spurious m.ready in IDLE falls through untouched; ready wins over a late valid drop.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_gnt       <= 1'b0;
         r_last      <= 1'b1;
         o_proto_err <= 1'b0;
      end else if (r_state == IDLE) begin
         if (s0.valid | s1.valid) begin
            r_gnt   <= (s0.valid & s1.valid) ? ~r_last : s1.valid;
            r_state <= BUSY;
         end
      end else if (m.ready) begin
         r_last  <= r_gnt;
         r_state <= IDLE;
      end else if (!w_valid) begin
         o_proto_err <= 1'b1;
         r_state     <= IDLE;
      end
   end
endmodule

// File: tb/tb_uni_arb2.sv
// tb_uni_arb2: scoreboard bench; stimulus queues expected forwards, monitors check them.
module tb_uni_arb2;
   localparam int AW = 32;
   localparam int DW = 128;
   localparam logic REQ_READ  = 1'b0;
   localparam logic REQ_WRITE = 1'b1;

   typedef struct {
      logic          typ;
      logic [AW-1:0] addr;
      logic [1:0]    size;
      logic          cach;
      logic [DW-1:0] wdata;
      int            drop;
   } mreq_t;
   typedef struct {
      int            mst;
      logic          typ;
      logic [AW-1:0] addr;
      logic [1:0]    size;
      logic          cach;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      int            lat;
      bit            noresp;
   } exp_t;
   typedef struct {
      int            mst;
      logic [DW-1:0] rdata;
   } rsp_t;
   typedef struct {
      logic [DW-1:0] rdata;
      int            lat;
   } dn_t;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   logic o_proto_err;
   uni_arb2_if #(.UNI_ADDR_WIDTH(AW), .UNI_DATA_WIDTH(DW)) s0_if ();
   uni_arb2_if #(.UNI_ADDR_WIDTH(AW), .UNI_DATA_WIDTH(DW)) s1_if ();
   uni_arb2_if #(.UNI_ADDR_WIDTH(AW), .UNI_DATA_WIDTH(DW)) m_if ();

   uni_arb2 #(.UNI_ADDR_WIDTH(AW), .UNI_DATA_WIDTH(DW)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .s0         (s0_if),
      .s1         (s1_if),
      .m          (m_if),
      .o_proto_err(o_proto_err)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   logic          v[2];
   logic          typ[2];
   logic [AW-1:0] a[2];
   logic [1:0]    sz[2];
   logic          ca[2];
   logic [DW-1:0] wd[2];
   logic          rdy[2];
   int            vstart[2];
   bit            mbusy[2];
   mreq_t         mq[2][$];
   exp_t          exp_q[$];
   rsp_t          rsp_q[$];
   dn_t           dn_q[$];

   assign s0_if.valid    = v[0];
   assign s0_if.reqtyp   = typ[0];
   assign s0_if.addr     = a[0];
   assign s0_if.size     = sz[0];
   assign s0_if.cachable = ca[0];
   assign s0_if.wdata    = wd[0];
   assign s1_if.valid    = v[1];
   assign s1_if.reqtyp   = typ[1];
   assign s1_if.addr     = a[1];
   assign s1_if.size     = sz[1];
   assign s1_if.cachable = ca[1];
   assign s1_if.wdata    = wd[1];
   assign rdy[0]         = s0_if.ready;
   assign rdy[1]         = s1_if.ready;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic mreq_t mk(input logic t, input logic [AW-1:0] ad, input logic [1:0] s,
                                input logic c, input logic [DW-1:0] w, input int drop = 0);
      mreq_t r;
      r = '{typ: t, addr: ad, size: s, cach: c, wdata: w, drop: drop};
      return r;
   endfunction

   task automatic issue(input int k, input mreq_t r);
      mq[k].push_back(r);
   endtask

   // Expected downstream forwards are queued in the order the arbiter must grant them.
   task automatic exp_fwd(input int k, input mreq_t r, input logic [DW-1:0] rd,
                          input int lat, input int dlat, input bit noresp = 1'b0);
      exp_t e;
      dn_t  d;
      e = '{mst: k, typ: r.typ, addr: r.addr, size: r.size, cach: r.cach,
            wdata: r.wdata, rdata: rd, lat: lat, noresp: noresp};
      d = '{rdata: rd, lat: dlat};
      exp_q.push_back(e);
      dn_q.push_back(d);
   endtask

   task automatic run_master(input int k);
      mreq_t r;
      int    n;
      forever begin
         @(posedge i_clk);
         #1;
         if (i_rst || mq[k].size() == 0) begin
            v[k]     = 1'b0;
            mbusy[k] = 1'b0;
         end else begin
            r         = mq[k].pop_front();
            mbusy[k]  = 1'b1;
            typ[k]    = r.typ;
            a[k]      = r.addr;
            sz[k]     = r.size;
            ca[k]     = r.cach;
            wd[k]     = r.wdata;
            v[k]      = 1'b1;
            vstart[k] = cyc;
            n         = 0;
            do begin
               @(negedge i_clk);
               n++;
            end while (!rdy[k] && !i_rst && !(r.drop > 0 && n >= r.drop) && n < 300);
            if (n >= 300) begin
               checks++;
               fails++;
               $display("FAIL master%0d_timeout: actual=no ready required=ready", k);
            end
         end
      end
   endtask

   // Downstream slave: answers each new forward after its queued latency.
   initial begin
      bit  active;
      int  cnt;
      dn_t d;
      active     = 1'b0;
      cnt        = 0;
      d          = '{rdata: '0, lat: 1};
      m_if.ready = 1'b0;
      m_if.rdata = '0;
      forever begin
         @(posedge i_clk);
         #1;
         m_if.ready = 1'b0;
         m_if.rdata = '0;
         if (i_rst || !m_if.valid) active = 1'b0;
         else if (!active) begin
            active = 1'b1;
            if (dn_q.size() > 0) d = dn_q.pop_front();
            else begin
               checks++;
               fails++;
               $display("FAIL dn_underflow: actual=empty required=entry");
            end
            cnt = d.lat;
         end else begin
            cnt--;
            if (cnt <= 0) begin
               m_if.ready = 1'b1;
               m_if.rdata = d.rdata;
               active     = 1'b0;
            end
         end
      end
   end

   // Monitor: forwarded requests, bubble after ready, and routed responses.
   initial begin
      bit   prev_v;
      bit   bubble;
      exp_t e;
      rsp_t r;
      prev_v = 1'b0;
      bubble = 1'b0;
      forever begin
         @(negedge i_clk);
         if (i_rst) begin
            prev_v = 1'b0;
            bubble = 1'b0;
         end else begin
            if (bubble) chk("bubble_after_ready", m_if.valid, 0);
            bubble = m_if.ready;
            if (m_if.valid && !prev_v) begin
               if (exp_q.size() == 0) chk("unexpected_fwd", m_if.addr, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("fwd_addr", m_if.addr, e.addr);
                  chk("fwd_reqtyp", m_if.reqtyp, e.typ);
                  chk("fwd_size", m_if.size, e.size);
                  chk("fwd_cachable", m_if.cachable, e.cach);
                  chk("fwd_wdata", m_if.wdata, e.wdata);
                  if (e.lat >= 0) chk("grant_latency", cyc - vstart[e.mst], e.lat);
                  if (!e.noresp) begin
                     r = '{mst: e.mst, rdata: e.rdata};
                     rsp_q.push_back(r);
                  end
               end
            end
            if (s0_if.ready || s1_if.ready) begin
               chk("ready_onehot", s0_if.ready & s1_if.ready, 0);
               if (rsp_q.size() == 0) chk("unexpected_ready", 1, 0);
               else begin
                  r = rsp_q.pop_front();
                  chk("rsp_master", s1_if.ready, r.mst);
                  chk("rsp_rdata", s1_if.ready ? s1_if.rdata : s0_if.rdata, r.rdata);
                  chk("other_rdata_zero", s1_if.ready ? s0_if.rdata : s1_if.rdata, 0);
               end
            end
            prev_v = m_if.valid;
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!(exp_q.size() == 0 && rsp_q.size() == 0 && mq[0].size() == 0 &&
                   mq[1].size() == 0 && !mbusy[0] && !mbusy[1]) && n < 500);
      checks++;
      if (n >= 500) begin
         fails++;
         $display("FAIL drain_timeout: actual=%0d pending required=0", exp_q.size() + rsp_q.size());
      end
      repeat (2) @(negedge i_clk);
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      mreq_t ra, rb, rc, rd;
      int    n;
      for (int k = 0; k < 2; k++) begin
         v[k] = 1'b0; typ[k] = 1'b0; a[k] = '0; sz[k] = '0; ca[k] = 1'b0; wd[k] = '0;
         vstart[k] = 0; mbusy[k] = 1'b0;
      end
      repeat (2) @(negedge i_clk);
      chk("rst_m_valid", m_if.valid, 0);
      chk("rst_s0_ready", s0_if.ready, 0);
      chk("rst_s1_ready", s1_if.ready, 0);
      chk("rst_s0_rdata", s0_if.rdata, 0);
      chk("rst_proto_err", o_proto_err, 0);
      i_rst = 1'b0;
      fork
         run_master(0);
         run_master(1);
      join_none

      // Single cachable read from master 0
      @(negedge i_clk);
      ra = mk(REQ_READ, 32'h8000_0000, 2'd2, 1'b1, '0);
      exp_fwd(0, ra, 128'h1122334455667788_99AABBCCDDEEF0FF, 1, 5);
      issue(0, ra);
      wait_idle();

      // Simultaneous requests from reset, twice: master 0 first both times
      do_reset();
      ra = mk(REQ_READ, 32'h0000_0100, 2'd2, 1'b0, '0);
      rb = mk(REQ_READ, 32'h0000_0200, 2'd1, 1'b1, '0);
      exp_fwd(0, ra, 128'hA0, 1, 2);
      exp_fwd(1, rb, 128'hB0, 5, 3);
      issue(0, ra);
      issue(1, rb);
      wait_idle();
      ra.addr = 32'h0000_0104;
      rb.addr = 32'h0000_0204;
      exp_fwd(0, ra, 128'hA1, 1, 2);
      exp_fwd(1, rb, 128'hB1, 5, 1);
      issue(0, ra);
      issue(1, rb);
      wait_idle();

      // Back-to-back writes from master 1
      ra = mk(REQ_WRITE, 32'h9000_0010, 2'd2, 1'b0, {4{32'hA5A5_A5A5}});
      rb = mk(REQ_WRITE, 32'h9000_0020, 2'd2, 1'b0, {16{8'hA5}} ^ 128'h1);
      exp_fwd(1, ra, '0, 1, 1);
      exp_fwd(1, rb, '0, 1, 2);
      issue(1, ra);
      issue(1, rb);
      wait_idle();

      // Master 1 streams; master 0 joins mid-stream and is served next
      ra = mk(REQ_READ, 32'hA000_0000, 2'd2, 1'b1, '0);
      rb = mk(REQ_READ, 32'hA000_0004, 2'd2, 1'b1, '0);
      rc = mk(REQ_READ, 32'hA000_0008, 2'd2, 1'b1, '0);
      rd = mk(REQ_READ, 32'hB000_0000, 2'd0, 1'b0, '0);
      exp_fwd(1, ra, 128'hC1, 1, 4);
      exp_fwd(0, rd, 128'hC0, 5, 1);
      exp_fwd(1, rb, 128'hC2, 4, 1);
      exp_fwd(1, rc, 128'hC3, 1, 1);
      issue(1, ra);
      issue(1, rb);
      issue(1, rc);
      repeat (2) @(negedge i_clk);
      issue(0, rd);
      wait_idle();

      // Granted master drops valid two cycles into BUSY
      ra = mk(REQ_READ, 32'hC000_0000, 2'd2, 1'b0, '0, 3);
      exp_fwd(0, ra, 128'hDEAD, 1, 10, 1'b1);
      issue(0, ra);
      wait_idle();
      chk("proto_err_set", o_proto_err, 1);
      chk("proto_m_valid", m_if.valid, 0);
      ra = mk(REQ_READ, 32'hC000_0100, 2'd2, 1'b0, '0);
      rb = mk(REQ_READ, 32'hC000_0200, 2'd2, 1'b0, '0);
      exp_fwd(0, ra, 128'hE0, 1, 1);
      exp_fwd(1, rb, 128'hE1, 4, 1);
      issue(0, ra);
      issue(1, rb);
      wait_idle();
      chk("proto_err_sticky", o_proto_err, 1);
      do_reset();
      @(negedge i_clk);
      chk("proto_err_cleared", o_proto_err, 0);

      // Asynchronous reset while BUSY
      ra = mk(REQ_READ, 32'hD000_0000, 2'd2, 1'b1, '0);
      exp_fwd(0, ra, 128'hF0, 1, 20, 1'b1);
      issue(0, ra);
      n = 0;
      while (!m_if.valid && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      chk("rst_busy_reached", m_if.valid, 1);
      @(posedge i_clk);
      #3;
      i_rst = 1'b1;
      #1;
      chk("async_rst_m_valid", m_if.valid, 0);
      chk("async_rst_s0_ready", s0_if.ready, 0);
      chk("async_rst_s1_ready", s1_if.ready, 0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
      wait_idle();
      ra = mk(REQ_READ, 32'hD000_0100, 2'd2, 1'b1, '0);
      rb = mk(REQ_WRITE, 32'hD000_0200, 2'd2, 1'b0, 128'h5A);
      exp_fwd(0, ra, 128'hF1, 1, 2);
      exp_fwd(1, rb, 128'hF2, 5, 1);
      issue(0, ra);
      issue(1, rb);
      wait_idle();

      chk("exp_q_drained", exp_q.size(), 0);
      chk("rsp_q_drained", rsp_q.size(), 0);
      chk("dn_q_drained", dn_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/uni_arb2.md
Name: uni_arb2

Overview:
- Two-master to one-slave arbiter on the unified memory request interface (uni_if).
- Sits directly upstream of the uni_if-to-AXI4 bridge. Master 0 is the instruction-fetch/icache port; master 1 is the LSU/dcache port.
- Grants one master at a time using round-robin and holds the grant until the downstream ready pulse.
- Forwards request fields downstream and response fields (ready, rdata) back to the granted master.

Parameters:
- UNI_ADDR_WIDTH, 32, request address width.
- UNI_DATA_WIDTH, 128, wdata/rdata width (one cache line, or one device word in the low bits).

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  asynchronous active-high reset.
- s0_valid  in  1  master 0 request valid; held high until s0_ready.
- s0_ready  out  1  master 0 completion pulse (1 cycle).
- s0_reqtyp  in  1  `REQ_READ / `REQ_WRITE.
- s0_addr  in  UNI_ADDR_WIDTH  byte address.
- s0_size  in  2  0=B, 1=H, 2=W.
- s0_cachable  in  1  1 = burst line access.
- s0_wdata  in  UNI_DATA_WIDTH  write data.
- s0_rdata  out  UNI_DATA_WIDTH  read data, valid while s0_ready=1.
- s1_*  same set as s0_*, for master 1.
- m_valid  out  1  downstream request valid.
- m_ready  in  1  downstream completion pulse; registered there, rdata stable while high.
- m_reqtyp, m_addr, m_size, m_cachable, m_wdata  out  widths as above  forwarded request fields.
- m_rdata  in  UNI_DATA_WIDTH  downstream read data.
- o_proto_err  out  1  sticky flag: granted master dropped valid before ready.

Behaviour:
- FSM states: IDLE, BUSY. Registers:
  - state
  - gnt (1 bit, granted index)
  - last (1 bit, last-served index)
  - o_proto_err
- Reset values: state=IDLE, gnt=0, last=1 (master 0 wins the first tie), o_proto_err=0. All outputs read 0 in IDLE except the pass-through request fields.
- IDLE with neither valid: stay in IDLE.
- IDLE with one valid: gnt <= that index; go to BUSY.
- IDLE with both valid: gnt <= ~last; go to BUSY.
- The decision is registered, so the grant takes effect the cycle after valid is first seen. Minimum added latency is 1 cycle.
- BUSY outputs:
  - m_valid = s<gnt>_valid.
  - All m_* request fields = s<gnt>_* (combinational mux on gnt).
  - In IDLE, m_valid=0 and request fields mux on gnt (don't-care).
- Response routing:
  - s<gnt>_ready = BUSY & m_ready. The other master's ready = 0.
  - s<gnt>_rdata = m_rdata. The other master's rdata = 0.
- BUSY & m_ready: last <= gnt; go to IDLE. One bubble cycle follows before the next grant. This covers the cycle in which the master drops valid after its ready pulse, so a stale valid is never re-forwarded.
- BUSY & ~s<gnt>_valid & ~m_ready (protocol violation): o_proto_err <= 1 (sticky until reset); go to IDLE; last unchanged.
- Non-granted master holding valid in BUSY: ignored, no ready. It is served on the next IDLE decision, so it waits at most one full transaction (no starvation).
- Request fields of the granted master must be stable while granted. The arbiter does not latch them.
- Asynchronous reset mid-transaction: state returns to IDLE immediately, m_valid drops, no ready is issued. The downstream bridge is reset by the same signal.
- m_ready seen in IDLE (spurious): ignored, no state change, no ready forwarded.

Test Plan:
- Single read, master 0:
  - Stimulus: s0 read addr=0x8000_0000, cachable=1; m_ready pulses 5 cycles after m_valid with m_rdata=0x1122..FF.
  - Required: m_valid rises 1 cycle after s0_valid; s0_ready=1 for exactly 1 cycle with s0_rdata=0x1122..FF; s1_ready stays 0.
- Simultaneous requests from reset:
  - Stimulus: s0 and s1 valid together.
  - Required: master 0 served first. After its ready and one IDLE cycle, master 1 is granted with m_addr=s1_addr.
  - Repeat with both valid: master 0 served before master 1 again (alternation).
- Back-to-back from master 1:
  - Stimulus: master 1 issues two writes (wdata=0xA5.., size=2, cachable=0) while s0 is idle.
  - Required: both forwarded in order; at least one IDLE cycle between m_ready and the next m_valid.
- Contention with stream:
  - Stimulus: master 1 streams continuously; master 0 asserts valid mid-stream.
  - Required: master 0 is granted immediately after the current master 1 transaction completes.
- Protocol error:
  - Stimulus: granted master drops valid 2 cycles into BUSY.
  - Required: o_proto_err=1, state returns to IDLE, o_proto_err stays 1 until i_rst.
- Reset mid-BUSY:
  - Stimulus: assert i_rst asynchronously (between clock edges) while BUSY.
  - Required: m_valid=0 and both s*_ready=0 immediately. After release, the first tie grants master 0.
